// File: rtl/aicd_sar_sequencer_pkg.sv
// Shared definitions for the SAR conversion sequencer: state encoding,
// default conversion parameters and a counter-width helper.
package aicd_sar_sequencer_pkg;

    // Conversion sequencer states (3-bit encoding kept from the original header)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Default conversion parameters
    localparam int unsigned DEF_NBITS      = 8;
    localparam int unsigned DEF_SAMPLE_CYC = 4;
    localparam int unsigned DEF_SETTLE_CYC = 3;

    // Bits needed for a counter running 0 .. max_cnt-1 (at least 1 bit)
    function automatic int unsigned cnt_width(input int unsigned max_cnt);
        int unsigned w;
        w = $clog2(max_cnt);
        return (w < 1) ? 1 : w;
    endfunction

    // Larger of two values, used to size the shared phase counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aicd_sync2.sv
// Two-flop synchronizer with synchronous active-low reset.
// Used for the async comparator decision and reusable for ui_in.
module aicd_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives a settled copy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aicd_sar_sequencer.sv
// SAR conversion sequencer: drives the track/hold switch and cap-DAC trial
// code, reads back the synchronized comparator decision and assembles the
// result one bit per trial, MSB first.
module aicd_sar_sequencer
    import aicd_sar_sequencer_pkg::*;
#(
    parameter int unsigned NBITS      = DEF_NBITS,
    parameter int unsigned SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample_o,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic             valid
);

    localparam int unsigned PH_W  = cnt_width(max_u(SAMPLE_CYC, SETTLE_CYC));
    localparam int unsigned IDX_W = cnt_width(NBITS);

    localparam logic [PH_W-1:0]  SAMPLE_LAST = PH_W'(SAMPLE_CYC - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);
    localparam logic [NBITS-1:0] CODE_MSB    = {1'b1, {(NBITS-1){1'b0}}};

    state_t           state, state_n;
    logic [PH_W-1:0]  phase, phase_n;
    logic [IDX_W-1:0] bit_idx, idx_n;
    logic [NBITS-1:0] code_n;
    logic [NBITS-1:0] result_n;
    logic             valid_n;
    logic             done_n;
    logic             sample_n;
    logic             busy_n;
    logic [NBITS-1:0] bit_mask;
    logic             cmp_sync;

    // Comparator output is asynchronous to clk
    aicd_sync2 #(
        .WIDTH (1)
    ) u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    // State and all outputs are registered; outputs load their next values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            phase    <= '0;
            bit_idx  <= '0;
            dac_code <= '0;
            result   <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            sample_o <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_idx  <= idx_n;
            dac_code <= code_n;
            result   <= result_n;
            valid    <= valid_n;
            done     <= done_n;
            sample_o <= sample_n;
            busy     <= busy_n;
        end
    end

    // Next-state, trial-code and result logic
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        idx_n    = bit_idx;
        code_n   = dac_code;
        result_n = result;
        valid_n  = valid;
        done_n   = 1'b0;
        bit_mask = NBITS'(1) << bit_idx;

        unique case (state)
            S_IDLE: begin
                code_n = '0;
                if (start && ena && !abort) begin
                    state_n = S_SAMPLE;
                    phase_n = '0;
                end
            end

            S_SAMPLE: begin
                if (phase == SAMPLE_LAST) begin
                    state_n = S_SETTLE;
                    phase_n = '0;
                    idx_n   = IDX_MSB;
                    code_n  = CODE_MSB;
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end

            S_SETTLE: begin
                if (phase == SETTLE_LAST) begin
                    state_n = S_DECIDE;
                    phase_n = '0;
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end

            S_DECIDE: begin
                // Keep the trial bit when Vin >= Vdac, otherwise drop it
                code_n = cmp_sync ? dac_code : (dac_code & ~bit_mask);
                if (bit_idx != '0) begin
                    code_n  = code_n | (bit_mask >> 1);
                    idx_n   = bit_idx - IDX_W'(1);
                    state_n = S_SETTLE;
                    phase_n = '0;
                end else begin
                    state_n = S_DONE;
                end
            end

            S_DONE: begin
                // dac_code still holds the final code during this cycle
                result_n = dac_code;
                valid_n  = 1'b1;
                done_n   = 1'b1;
                code_n   = '0;
                phase_n  = '0;
                state_n  = (cont && ena) ? S_SAMPLE : S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
                code_n  = '0;
                phase_n = '0;
            end
        endcase

        // Abort or disable wins over any in-flight step, including DONE
        if (state != S_IDLE && (abort || !ena)) begin
            state_n  = S_IDLE;
            phase_n  = '0;
            code_n   = '0;
            result_n = result;
            valid_n  = valid;
            done_n   = 1'b0;
        end

        sample_n = (state_n == S_SAMPLE);
        busy_n   = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_aicd_sar_sequencer.sv
// Self-checking bench for aicd_sar_sequencer with a behavioural comparator
// model cmp_in = (vin_code >= dac_code).
module tb_aicd_sar_sequencer;

    localparam int unsigned NB  = 8;
    localparam int          LAT = 37;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic          cont;
    logic          abort;
    logic          cmp_in;
    logic          sample_o;
    logic [NB-1:0] dac_code;
    logic          busy;
    logic          done;
    logic [NB-1:0] result;
    logic          valid;
    logic [NB-1:0] vin_code;

    int n_cmp;
    int n_bad;

    aicd_sar_sequencer #(
        .NBITS      (8),
        .SAMPLE_CYC (4),
        .SETTLE_CYC (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .cont     (cont),
        .abort    (abort),
        .cmp_in   (cmp_in),
        .sample_o (sample_o),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .valid    (valid)
    );

    assign cmp_in = (vin_code >= dac_code);

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] vin;
        logic [NB-1:0] exp_result;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start at the next edge, then wait (bounded) for done; lat=0 on timeout
    task automatic convert(input logic [NB-1:0] vin, output int lat);
        vin_code = vin;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;
        int   cnt;
        int   busy_low;

        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        abort    = 1'b0;
        vin_code = '0;

        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h01, 8'h01};
        vecs[4] = '{8'h80, 8'h80};
        vecs[5] = '{8'h7F, 8'h7F};
        vecs[6] = '{8'hA5, 8'hA5};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sample_o", int'(sample_o), 0);
        chk("rst_dac_code", int'(dac_code), 0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_done",     int'(done),     0);
        chk("rst_result",   int'(result),   0);
        chk("rst_valid",    int'(valid),    0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single conversions
        for (int unsigned i = 0; i < 7; i++) begin
            convert(vecs[i].vin, lat);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk($sformatf("v%0d_result", i), int'(result), int'(vecs[i].exp_result));
            chk($sformatf("v%0d_valid", i), int'(valid), 1);
            chk($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
            chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
        end

        // Sample window and first trial codes, vin=0x40
        vin_code = 8'h40;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("smp_sample_o_c0", int'(sample_o), 1);
        chk("smp_dac_c0",      int'(dac_code), 0);
        chk("smp_busy_c0",     int'(busy),     1);
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) chk("smp_sample_o_c3", int'(sample_o), 1);
            if (n == 4) begin
                chk("smp_sample_o_c4", int'(sample_o), 0);
                chk("smp_dac_c4",      int'(dac_code), 'h80);
            end
            if (n == 8) chk("smp_dac_c8", int'(dac_code), 'h40);
            if (n == 36) chk("smp_no_early_done", int'(done), 0);
        end
        chk("smp_done", int'(done), 1);
        chk("smp_result", int'(result), 'h40);
        @(negedge clk);

        // Continuous mode: back-to-back conversions with no IDLE gap
        cont = 1'b1;
        convert(8'h3C, lat);
        chk("cont_lat1", lat, LAT);
        chk("cont_res1", int'(result), 'h3C);
        chk("cont_busy_at_done1", int'(busy), 1);
        vin_code = 8'hC3;
        cont     = 1'b0;
        lat      = 0;
        busy_low = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_low++;
        end
        chk("cont_spacing", lat, LAT);
        chk("cont_res2", int'(result), 'hC3);
        chk("cont_no_idle_gap", busy_low, 0);
        chk("cont_stop_busy", int'(busy), 0);
        @(negedge clk);

        // Abort mid-conversion after a 0xA5 result
        convert(8'hA5, lat);
        chk("abt_pre_result", int'(result), 'hA5);
        @(negedge clk);
        vin_code = 8'h12;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abt_busy",     int'(busy),     0);
        chk("abt_sample_o", int'(sample_o), 0);
        chk("abt_dac",      int'(dac_code), 0);
        chk("abt_done",     int'(done),     0);
        chk("abt_result",   int'(result),   'hA5);
        chk("abt_valid",    int'(valid),    1);
        cnt = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abt_no_done", cnt, 0);

        // Abort and start together in IDLE: stays IDLE
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abt_start_idle_busy", int'(busy), 0);
        abort = 1'b0;
        start = 1'b0;

        // start with ena=0 is ignored; ena drop mid-conversion forces IDLE
        ena   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ena0_start_busy", int'(busy), 0);
        ena = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("ena_mid_busy_before", int'(busy), 1);
        ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ena_mid_busy", int'(busy), 0);
        chk("ena_mid_result", int'(result), 'hA5);
        ena = 1'b1;
        @(negedge clk);

        // start held while busy: exactly one conversion
        vin_code = 8'h5A;
        start    = 1'b1;
        cnt      = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 20) start = 1'b0;
            if (done) cnt++;
        end
        chk("hold_start_dones", cnt, 1);
        chk("hold_start_result", int'(result), 'h5A);

        // Reset mid-conversion clears every output
        vin_code = 8'h77;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_sample_o", int'(sample_o), 0);
        chk("mrst_dac",      int'(dac_code), 0);
        chk("mrst_busy",     int'(busy),     0);
        chk("mrst_done",     int'(done),     0);
        chk("mrst_result",   int'(result),   0);
        chk("mrst_valid",    int'(valid),    0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
